// File: rtl/blockade_rom_loader.sv
// Blockade ROM download writer: strips a one-byte mode header off the HPS byte stream,
// issues paced dn_wr pulses into the ROM images and holds the core in reset until a good image lands.
module blockade_rom_loader #(
   parameter int unsigned ROM_BYTES    = 5120,
   parameter int unsigned WR_GAP       = 1,
   parameter int unsigned RESET_HOLD   = 16,
   parameter logic [1:0]  DEFAULT_MODE = 2'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [13:0] dn_addr,
   output logic [7:0]  dn_data,
   output logic        dn_wr,
   output logic [1:0]  game_mode,
   output logic        core_reset,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam logic [13:0] LP_LAST = 14'(ROM_BYTES);
   localparam logic [3:0]  LP_GAP  = 4'(WR_GAP);
   localparam logic [7:0]  LP_HOLD = 8'(RESET_HOLD);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_DATA,
      S_DRAIN,
      S_HOLD,
      S_FAIL
   } state_t;

   state_t      r_state, w_state_nxt;
   logic        r_load_q;
   logic        r_end_pend, w_end_pend_nxt;
   logic [13:0] r_cnt, w_cnt_nxt;
   logic [3:0]  r_gap, w_gap_nxt;
   logic [7:0]  r_hold, w_hold_nxt;
   logic [13:0] r_dn_addr, w_dn_addr_nxt;
   logic [7:0]  r_dn_data, w_dn_data_nxt;
   logic        r_dn_wr, w_dn_wr_nxt;
   logic [1:0]  r_mode, w_mode_nxt;
   logic        r_core_reset, w_core_reset_nxt;
   logic        r_busy, w_busy_nxt;
   logic        r_done, w_done_nxt;
   logic        r_error, w_error_nxt;

   logic        w_load_rise;
   logic        w_load_fall;
   logic        w_active;
   logic        w_ready;
   logic        w_accept;
   logic [13:0] w_cnt_inc;

   assign w_load_rise = load & ~r_load_q;
   assign w_load_fall = ~load & r_load_q;
   assign w_active    = (r_state == S_HEADER) || (r_state == S_DATA) || (r_state == S_DRAIN);
   assign w_cnt_inc   = r_cnt + 14'd1;

   // The stream is closed for the one cycle in which the end-of-load decision is taken,
   // so the counter and error flag it looks at can no longer move underneath it.
   assign w_ready  = ~r_end_pend &&
                     ((r_state == S_HEADER) || (r_state == S_DRAIN) ||
                      ((r_state == S_DATA) && (r_gap == '0)));
   assign w_accept = w_ready & s_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_load_q     <= 1'b0;
         r_end_pend   <= 1'b0;
         r_cnt        <= '0;
         r_gap        <= '0;
         r_hold       <= '0;
         r_dn_addr    <= '0;
         r_dn_data    <= '0;
         r_dn_wr      <= 1'b0;
         r_mode       <= DEFAULT_MODE;
         r_core_reset <= 1'b1;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_load_q     <= load;
         r_end_pend   <= w_end_pend_nxt;
         r_cnt        <= w_cnt_nxt;
         r_gap        <= w_gap_nxt;
         r_hold       <= w_hold_nxt;
         r_dn_addr    <= w_dn_addr_nxt;
         r_dn_data    <= w_dn_data_nxt;
         r_dn_wr      <= w_dn_wr_nxt;
         r_mode       <= w_mode_nxt;
         r_core_reset <= w_core_reset_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         r_error      <= w_error_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_end_pend_nxt   = r_end_pend;
      w_cnt_nxt        = r_cnt;
      w_gap_nxt        = r_gap;
      w_hold_nxt       = r_hold;
      w_dn_addr_nxt    = r_dn_addr;
      w_dn_data_nxt    = r_dn_data;
      w_dn_wr_nxt      = 1'b0;
      w_mode_nxt       = r_mode;
      w_core_reset_nxt = r_core_reset;
      w_busy_nxt       = r_busy;
      w_done_nxt       = r_done;
      w_error_nxt      = r_error;

      if (w_load_rise) begin
         w_state_nxt      = S_HEADER;
         w_end_pend_nxt   = 1'b0;
         w_cnt_nxt        = '0;
         w_gap_nxt        = '0;
         w_core_reset_nxt = 1'b1;
         w_busy_nxt       = 1'b1;
         w_done_nxt       = 1'b0;
         w_error_nxt      = 1'b0;
      end else begin
         unique case (r_state)
            S_HEADER: begin
               if (w_accept) begin
                  if (s_data[7:2] == '0) begin
                     w_mode_nxt  = s_data[1:0];
                     w_state_nxt = S_DATA;
                  end else begin
                     w_error_nxt = 1'b1;
                     w_state_nxt = S_DRAIN;
                  end
               end
            end
            S_DATA: begin
               if (r_gap != '0) begin
                  w_gap_nxt = r_gap - 4'd1;
               end
               if (w_accept) begin
                  w_dn_wr_nxt   = 1'b1;
                  w_dn_addr_nxt = r_cnt;
                  w_dn_data_nxt = s_data;
                  w_cnt_nxt     = w_cnt_inc;
                  w_gap_nxt     = LP_GAP;
                  if (w_cnt_inc == LP_LAST) begin
                     w_state_nxt = S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (w_accept) begin
                  w_error_nxt = 1'b1;
               end
            end
            S_HOLD: begin
               if (r_hold == '0) begin
                  w_core_reset_nxt = 1'b0;
                  w_state_nxt      = S_IDLE;
               end else begin
                  w_hold_nxt = r_hold - 8'd1;
               end
            end
            default: begin
            end
         endcase

         // The falling edge only arms the decision; it is resolved one cycle later so a byte
         // taken on the falling cycle is already counted.
         if (w_active) begin
            if (r_end_pend) begin
               w_end_pend_nxt = 1'b0;
               w_busy_nxt     = 1'b0;
               if ((r_cnt == LP_LAST) && !r_error) begin
                  w_state_nxt = S_HOLD;
                  w_hold_nxt  = LP_HOLD;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = S_FAIL;
                  w_error_nxt = 1'b1;
               end
            end else if (w_load_fall) begin
               w_end_pend_nxt = 1'b1;
            end
         end
      end
   end

   assign s_ready    = w_ready;
   assign dn_addr    = r_dn_addr;
   assign dn_data    = r_dn_data;
   assign dn_wr      = r_dn_wr;
   assign game_mode  = r_mode;
   assign core_reset = r_core_reset;
   assign busy       = r_busy;
   assign done       = r_done;
   assign error      = r_error;

endmodule

// File: doc/blockade_rom_loader.md
# blockade_rom_loader

Download-side writer for the Blockade core's ROM load port. It takes the HPS byte stream over a valid/ready handshake, strips and decodes a one-byte header, and drives `dn_addr`/`dn_wr`/`dn_data` with paced single-cycle write pulses into the program ROM and graphics PROM images. It holds the core in reset until a complete, well-formed image has been written.

## Interface
- `ROM_BYTES`, 5120: payload length in bytes; the image occupies `dn_addr` 0x0000–0x13FF.
- `WR_GAP`, 1: idle cycles after each write pulse before the next byte is accepted (0–15).
- `RESET_HOLD`, 16: cycles `core_reset` stays high after a successful load (1–255).
- `DEFAULT_MODE`, 0: `game_mode` value after reset.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high.
- `load`  in  1: download window; a rising edge starts a load, a falling edge ends it.
- `s_data`  in  8: stream byte.
- `s_valid`  in  1: `s_data` is valid.
- `s_ready`  out  1: the loader accepts a byte this cycle.
- `dn_addr`  out  14: write address.
- `dn_data`  out  8: write data.
- `dn_wr`  out  1: one-cycle write strobe.
- `game_mode`  out  2: decoded header mode.
- `core_reset`  out  1: reset to the core.
- `busy`  out  1: a load is in progress.
- `done`  out  1: the last load succeeded.
- `error`  out  1: the last load failed.

## Operation
- A byte transfers when `s_valid && s_ready` at a rising clock edge.
- States:
  - IDLE: `s_ready`=0. The `load` rising edge goes to HEADER and clears `done`, `error` and the byte counter. `core_reset`=1 and `busy`=1.
  - HEADER: `s_ready`=1. On accept, if bits [7:2] are zero, latch bits [1:0] into `game_mode` and go to DATA. If bits [7:2] are nonzero, set `error`, leave `game_mode` unchanged, and go to DRAIN.
  - DATA: `s_ready`=1 when the gap counter is 0. Each accepted byte is registered to `dn_data` with `dn_addr` = counter, and `dn_wr` pulses. The counter increments, and the gap counter loads `WR_GAP`. When the counter reaches `ROM_BYTES`, go to DRAIN.
  - GAP: a sub-condition of DATA. `s_ready`=0 while the gap counter is nonzero; the gap counter decrements by one per cycle.
  - DRAIN: `s_ready`=1. Every accepted byte sets `error` (overlong) and is discarded; `dn_wr` stays 0.
  - HOLD: `done`=1 and `busy`=0. The hold counter runs from `RESET_HOLD` down to 0, then `core_reset`=0 and the state goes to IDLE.
  - FAIL: `error`=1, `busy`=0, `core_reset`=1. Stays until the next `load` rising edge.
- `load` falling edge, from HEADER, DATA or DRAIN:
  - Go to HOLD if counter == `ROM_BYTES` and `error`=0.
  - Otherwise go to FAIL. This covers a short load and a zero-byte load.
- A byte accepted in the same cycle that `load` falls is written and counted before the end decision. The decision is taken in the next cycle.
- A `load` rising edge in any state, including HOLD and FAIL, restarts at HEADER. The counter is cleared, `core_reset` is re-asserted, and `game_mode` keeps its value until a new header is accepted.
- Width rules:
  - The counter is 14 bits and never exceeds `ROM_BYTES`.
  - `dn_addr` holds its last value when `dn_wr`=0.
  - `dn_data` is passed through unmasked. The destination ROMs use only bits [3:0].

## Timing
- Reset values:
  - `s_ready`=0, `dn_wr`=0, `dn_addr`=0, `dn_data`=0.
  - `game_mode`=`DEFAULT_MODE`, `core_reset`=1.
  - `busy`=0, `done`=0, `error`=0.
  - State is IDLE.
- The `load` edge is detected using a registered copy of `load`. The state is HEADER one cycle after the first cycle in which `load` is sampled high.
- Write latency:
  - A byte accepted at edge N gives `dn_wr`=1 during cycle N+1 only, with `dn_addr` and `dn_data` stable in that cycle.
  - `s_ready` is low during cycles N+1 through N+`WR_GAP`.
  - With `WR_GAP`=0 there is one write per cycle and `s_ready` stays high.
- Release latency: `core_reset` falls `RESET_HOLD`+1 cycles after the HOLD entry edge.
- Reset asserted mid-load: all outputs take their reset values immediately and asynchronously; no further `dn_wr` occurs.

## Test plan
- Nominal load: header 0x02 followed by 5120 bytes (value = address[7:0]), then `load` falls. Expect 5120 `dn_wr` pulses with addresses 0x0000–0x13FF, `game_mode`=2, `done`=1, `error`=0, and `core_reset` low 17 cycles after HOLD entry.
- Pacing (`WR_GAP`=3, `s_valid` held high): `s_ready` repeats the pattern 1,0,0,0. `dn_wr` is spaced 4 cycles apart, and the first `dn_wr` appears one cycle after the first accept.
- Short load: header plus 100 bytes, then `load` falls. Expect `error`=1, `done`=0, `core_reset` stays 1, and the last `dn_addr` = 0x0063.
- Overlong and bad header:
  - 5121 payload bytes: exactly 5120 writes, `error`=1 after the end.
  - Header 0x84: `error`=1, `game_mode` unchanged, no writes.
- Restart and reset:
  - Raise `load` again during HOLD: expect `core_reset` back to 1, `done`=0, and a new header accepted.
  - Assert `reset` after 50 data bytes: all outputs at reset values in the same cycle, with no further `dn_wr`.
